// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: index modes, counter constants
// and the PHT index hash.
package bp_pkg;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;

    // Weakly not-taken: the value just below the taken/not-taken midpoint.
    function automatic int unsigned ctr_init(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    function automatic int unsigned ctr_max(input int unsigned ctr_bits);
        return (32'd1 << ctr_bits) - 32'd1;
    endfunction

    // pc_bits and ghr arrive zero-extended, so the GHR lands on the index LSBs.
    function automatic logic [31:0] bp_hash(input logic [31:0] pc_bits,
                                            input logic [31:0] ghr,
                                            input int          mode);
        return (mode == BP_MODE_GSHARE) ? (pc_bits ^ ghr) : pc_bits;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_BITS saturating counters with one registered
// read port and one saturating-update write port.
module bp_pht
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd_en,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_taken,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_max(CTR_BITS));

    logic [CTR_BITS-1:0] mem_q [ENTRIES];
    logic [CTR_BITS-1:0] mem_d [ENTRIES];
    logic [CTR_BITS-1:0] rd_ctr_q, rd_ctr_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            if (wr_taken && (mem_q[wr_idx] != CTR_MAX)) begin
                mem_d[wr_idx] = mem_q[wr_idx] + CTR_BITS'(1);
            end else if (!wr_taken && (mem_q[wr_idx] != '0)) begin
                mem_d[wr_idx] = mem_q[wr_idx] - CTR_BITS'(1);
            end
        end
        // Reads see mem_q, so a same-cycle write to the same entry is not visible.
        rd_ctr_d = rd_en ? mem_q[rd_idx] : rd_ctr_q;
    end

    // NOTE: the counter array is reset on purpose: a predictor that starts from
    // arbitrary counters gives run-to-run different predictions after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= CTR_INIT;
            end
            rd_ctr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ctr_q <= rd_ctr_d;
        end
    end

    assign rd_taken = rd_ctr_q[CTR_BITS-1];

endmodule

// File: rtl/branch_predictor_pht.sv
// Dynamic branch predictor: bimodal or gshare indexing into a PHT, with a
// non-speculative global history and resolved-branch statistics.
module branch_predictor_pht
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 4,
    parameter int MODE     = BP_MODE_BIMODAL
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [31:0]         req_pc,
    output logic                resp_valid,
    output logic                resp_taken,
    output logic [IDX_BITS-1:0] resp_idx,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken,
    input  logic                upd_predicted,
    output logic [GHR_BITS-1:0] ghr_o,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);

    logic [IDX_BITS-1:0] req_idx;
    logic                resp_valid_q, resp_valid_d;
    logic [IDX_BITS-1:0] resp_idx_q, resp_idx_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         branches_q, branches_d;
    logic [31:0]         mispredicts_q, mispredicts_d;
    logic                unused_pc;

    assign unused_pc = ^{req_pc[31:IDX_BITS+2], req_pc[1:0]};

    always_comb begin
        req_idx      = IDX_BITS'(bp_hash(32'(req_pc[IDX_BITS+1:2]), 32'(ghr_q), MODE));
        resp_valid_d = req_valid;
        resp_idx_d   = req_valid ? req_idx : resp_idx_q;

        // Truncating {ghr, taken} drops the oldest bit; also covers GHR_BITS == 1.
        ghr_d         = upd_valid ? GHR_BITS'({ghr_q, upd_taken}) : ghr_q;
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (upd_valid) begin
            if (branches_q != '1) branches_d = branches_q + 32'd1;
            if ((upd_taken != upd_predicted) && (mispredicts_q != '1)) begin
                mispredicts_d = mispredicts_q + 32'd1;
            end
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q  <= 1'b0;
            resp_idx_q    <= '0;
            ghr_q         <= '0;
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            resp_valid_q  <= resp_valid_d;
            resp_idx_q    <= resp_idx_d;
            ghr_q         <= ghr_d;
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    bp_pht #(
        .IDX_BITS (IDX_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (req_valid),
        .rd_idx   (req_idx),
        .rd_taken (resp_taken),
        .wr_en    (upd_valid),
        .wr_idx   (upd_idx),
        .wr_taken (upd_taken)
    );

    assign resp_valid       = resp_valid_q;
    assign resp_idx         = resp_idx_q;
    assign ghr_o            = ghr_q;
    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;

endmodule
